// File: rtl/dmux8way_arbiter_if.sv
// Request/grant bundle between eight requesters and the DMux8Way routing arbiter.
interface dmux8way_arbiter_if;
   localparam int unsigned N     = 8;
   localparam int unsigned SEL_W = 3;

   logic [N-1:0]     req;
   logic [N-1:0]     grant;
   logic [SEL_W-1:0] sel;
   logic             dmux_in;
   logic             busy;

   modport master (output req, input grant, sel, dmux_in, busy);
   modport slave  (input req, output grant, sel, dmux_in, busy);
endinterface

// File: rtl/dmux8way_arbiter.sv
// Round-robin arbiter that owns the shared DMux8Way load-routing path and
// holds each grant until release or until the hold limit expires.
module dmux8way_arbiter #(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CNT_W    = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   dmux8way_arbiter_if.slave   bus
);
   localparam int unsigned N     = 8;
   localparam int unsigned SEL_W = 3;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t           state, state_d;
   logic [SEL_W-1:0] ptr, ptr_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [N-1:0]     grant, grant_d;
   logic [SEL_W-1:0] sel, sel_d;
   logic             dmux_in, dmux_in_d;
   logic             busy, busy_d;
   logic [SEL_W-1:0] win;
   logic             hold_expired;

   // First requester after ptr in circular order; 3-bit sums wrap naturally.
   always_comb begin
      win = '0;
      for (int unsigned i = N; i >= 1; i--) begin
         if (bus.req[ptr + SEL_W'(i)]) win = ptr + SEL_W'(i);
      end
   end

   assign hold_expired = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= SEL_W'(7);
         cnt     <= '0;
         grant   <= '0;
         sel     <= '0;
         dmux_in <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_d;
         ptr     <= ptr_d;
         cnt     <= cnt_d;
         grant   <= grant_d;
         sel     <= sel_d;
         dmux_in <= dmux_in_d;
         busy    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state;
      ptr_d     = ptr;
      cnt_d     = cnt;
      grant_d   = grant;
      sel_d     = sel;
      dmux_in_d = dmux_in;
      busy_d    = busy;
      case (state)
         IDLE: begin
            if (bus.req != '0) begin
               sel_d     = win;
               grant_d   = N'(1) << win;
               dmux_in_d = 1'b1;
               busy_d    = 1'b1;
               cnt_d     = CNT_W'(1);
               state_d   = GRANT;
            end
         end
         GRANT: begin
            // Other requests are ignored until the owner lets go or times out.
            if (!bus.req[sel] || hold_expired) begin
               grant_d   = '0;
               dmux_in_d = 1'b0;
               ptr_d     = sel;
               state_d   = GAP;
            end else if (MAX_HOLD != 0) begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         GAP: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            grant_d   = '0;
            dmux_in_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   assign bus.grant   = grant;
   assign bus.sel     = sel;
   assign bus.dmux_in = dmux_in;
   assign bus.busy    = busy;
endmodule

// File: tb/tb_dmux8way_arbiter.sv
// Scoreboard bench: three arbiters (hold limits 4, 2, unlimited) share one
// request stream and are checked against a transaction-level model.
module tb_dmux8way_arbiter;
   typedef struct packed {
      logic [7:0] grant;
      logic [2:0] sel;
      logic       dmux;
      logic       busy;
   } exp_t;
   typedef exp_t [2:0] exp3_t;

   logic  clk;
   logic  rst_n;
   int    checks;
   int    errors;
   exp3_t sbq[$];
   exp3_t act;

   int ptr_m[3];
   int owner_m[3];
   int held_m[3];
   int sel_m[3];
   bit gap_m[3];
   int mh[3] = '{4, 2, 0};

   dmux8way_arbiter_if bus0 ();
   dmux8way_arbiter_if bus1 ();
   dmux8way_arbiter_if bus2 ();

   dmux8way_arbiter #(.MAX_HOLD(4), .CNT_W(3)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   dmux8way_arbiter #(.MAX_HOLD(2), .CNT_W(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   dmux8way_arbiter #(.MAX_HOLD(0), .CNT_W(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   assign act = {{bus2.grant, bus2.sel, bus2.dmux_in, bus2.busy},
                 {bus1.grant, bus1.sel, bus1.dmux_in, bus1.busy},
                 {bus0.grant, bus0.sel, bus0.dmux_in, bus0.busy}};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int m = 0; m < 3; m++) begin
         ptr_m[m]   = 7;
         owner_m[m] = -1;
         held_m[m]  = 0;
         sel_m[m]   = 0;
         gap_m[m]   = 1'b0;
      end
   endfunction

   // Transaction view: an owner holds the path until it drops its request or
   // uses up its hold budget, then one dead cycle, then the next scan from ptr.
   function automatic exp_t model_step(int m, logic [7:0] r);
      exp_t e;
      if (gap_m[m]) begin
         gap_m[m] = 1'b0;
      end else if (owner_m[m] >= 0) begin
         if (!r[owner_m[m]] || (mh[m] != 0 && held_m[m] == mh[m])) begin
            ptr_m[m]   = owner_m[m];
            owner_m[m] = -1;
            gap_m[m]   = 1'b1;
         end else begin
            held_m[m]++;
         end
      end else if (r != 8'h00) begin
         for (int k = 1; k <= 8; k++) begin
            int c;
            c = (ptr_m[m] + k) % 8;
            if (r[c]) begin
               owner_m[m] = c;
               sel_m[m]   = c;
               held_m[m]  = 1;
               break;
            end
         end
      end
      e.grant = (owner_m[m] >= 0) ? (8'h01 << owner_m[m]) : 8'h00;
      e.sel   = 3'(sel_m[m]);
      e.dmux  = (owner_m[m] >= 0);
      e.busy  = (owner_m[m] >= 0) || gap_m[m];
      return e;
   endfunction

   task automatic cyc(input logic [7:0] r);
      exp3_t e;
      @(negedge clk);
      bus0.req = r;
      bus1.req = r;
      bus2.req = r;
      for (int m = 0; m < 3; m++) e[m] = model_step(m, r);
      sbq.push_back(e);
   endtask

   task automatic check_zero(input string name);
      for (int m = 0; m < 3; m++) begin
         checks++;
         if (act[m] != 13'h0) begin
            errors++;
            $display("FAIL %s inst%0d: got grant=%h sel=%0d dmux_in=%b busy=%b, expected all zero",
                     name, m, act[m].grant, act[m].sel, act[m].dmux, act[m].busy);
         end
      end
   endtask

   // Monitor: per-cycle invariants plus in-order scoreboard comparison.
   initial begin
      exp3_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            for (int m = 0; m < 3; m++) begin
               checks++;
               if (((act[m].grant & (act[m].grant - 8'h01)) != 8'h00) ||
                   (act[m].grant != (8'(act[m].dmux) << act[m].sel)) ||
                   (act[m].dmux && !act[m].busy)) begin
                  errors++;
                  $display("FAIL invariant inst%0d: got grant=%h sel=%0d dmux_in=%b busy=%b",
                           m, act[m].grant, act[m].sel, act[m].dmux, act[m].busy);
               end
            end
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               for (int m = 0; m < 3; m++) begin
                  checks++;
                  if (act[m] != e[m]) begin
                     errors++;
                     $display("FAIL scoreboard inst%0d @%0t: got grant=%h sel=%0d dmux_in=%b busy=%b, expected grant=%h sel=%0d dmux_in=%b busy=%b",
                              m, $time, act[m].grant, act[m].sel, act[m].dmux, act[m].busy,
                              e[m].grant, e[m].sel, e[m].dmux, e[m].busy);
                  end
               end
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus0.req = 8'h00;
      bus1.req = 8'h00;
      bus2.req = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check_zero("reset_values");
      rst_n = 1'b1;

      // Full contention: rotation 0..7 then back to 0.
      repeat (52) cyc(8'hFF);
      repeat (3) cyc(8'h00);
      // Early release, then scan from the released index.
      repeat (2) cyc(8'h10);
      repeat (3) cyc(8'h00);
      repeat (8) cyc(8'h11);
      repeat (3) cyc(8'h00);
      // Sole requester at the wrap point.
      repeat (14) cyc(8'h80);
      repeat (3) cyc(8'h00);
      // Park ptr at 1, then a long request on bit 2 with bit 0 waiting.
      repeat (3) cyc(8'h02);
      repeat (3) cyc(8'h00);
      repeat (20) cyc(8'h05);
      repeat (6) cyc(8'h01);
      repeat (3) cyc(8'h00);

      // Asynchronous reset while requester 3 owns the path.
      repeat (2) cyc(8'h08);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      model_reset();
      sbq.delete();
      @(posedge clk);
      #2;
      check_zero("reset_held");
      rst_n = 1'b1;
      repeat (3) cyc(8'h01);
      repeat (3) cyc(8'h00);

      // Random traffic, biased towards sparse and idle request patterns.
      for (int i = 0; i < 600; i++) begin
         logic [7:0] r;
         case ($urandom_range(0, 3))
            0:       r = 8'h00;
            1:       r = 8'($urandom) & 8'($urandom) & 8'($urandom);
            default: r = 8'($urandom);
         endcase
         cyc(r);
      end
      cyc(8'h00);

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
      #3;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
